// File: rtl/fft_pkg.sv
// Shared types and index helpers for the radix-2 FFT read-side address sequencer.
package fft_pkg;

    localparam int LOG2_LEN_W = 4;
    localparam int FN_W       = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_GAP  = 2'd2,
        S_OUTP = 2'd3
    } state_e;

    // Reverse the low w bits of v; bits at w and above come back as zero.
    function automatic logic [FN_W-1:0] bit_reverse(input logic [FN_W-1:0] v,
                                                    input int unsigned     w);
        logic [FN_W-1:0] r;
        r = '0;
        for (int i = 0; i < FN_W; i++) begin
            r[FN_W-1-i] = v[i];
        end
        return r >> (FN_W - w);
    endfunction

    function automatic logic [FN_W-1:0] insert_zero_bit(input logic [FN_W-1:0]       v,
                                                        input logic [LOG2_LEN_W-1:0] pos);
        logic [FN_W-1:0] low_mask;
        low_mask = (FN_W'(1) << pos) - FN_W'(1);
        return ((v & ~low_mask) << 1) | (v & low_mask);
    endfunction

endpackage

// File: rtl/fft_rd_valid_dly.sv
// Delays the read strobe by the RAM read latency to mark returning read data.
module fft_rd_valid_dly
    import fft_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vld_i,
    output logic vld_o
);

    if (RD_LATENCY == 0) begin : g_passthru
        assign vld_o = vld_i;
    end else begin : g_shift
        logic [RD_LATENCY-1:0] sr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr_q <= '0;
            end else begin
                sr_q <= (sr_q << 1) | RD_LATENCY'(vld_i);
            end
        end

        assign vld_o = sr_q[RD_LATENCY-1];
    end

endmodule

// File: rtl/fft_rd_addr_gen.sv
// Read-side address sequencer for the in-place radix-2 FFT: butterfly operand and
// twiddle addresses per level, inter-level gaps, and an optional output read pass.
module fft_rd_addr_gen
    import fft_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int TW_WIDTH   = ADDR_WIDTH - 1,
    parameter int LEVEL_GAP  = 2,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [LOG2_LEN_W-1:0] log2_len_i,
    input  logic                  out_en_i,
    input  logic                  bitrev_out_i,
    input  logic                  stall_i,
    input  logic                  abort_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [TW_WIDTH-1:0]   tw_addr_o,
    output logic                  rd_valid_o,
    output logic [LOG2_LEN_W-1:0] level_o,
    output logic                  first_level_o,
    output logic                  last_level_o,
    output logic                  out_phase_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  len_err_o
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rc_q, rc_d;
    logic [LOG2_LEN_W-1:0]   level_q, level_d;
    logic [LOG2_LEN_W-1:0]   len_q, len_d;
    logic [3:0]              gcnt_q, gcnt_d;
    logic                    out_en_q, out_en_d;
    logic                    bitrev_q, bitrev_d;
    logic                    pend_out_q, pend_out_d;

    logic                    rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [TW_WIDTH-1:0]     tw_addr_q, tw_addr_d;
    logic [LOG2_LEN_W-1:0]   lvl_out_q, lvl_out_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;
    logic                    outp_q, outp_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    len_err_q, len_err_d;

    logic                    len_ok, accept, issue;
    logic                    rc_last, level_last, gap_last;
    logic [ADDR_WIDTH-1:0]   len_mask, b_idx, base, pair, bfly_addr, out_addr;
    logic [TW_WIDTH-1:0]     tw_val;

    // A new start is refused until the previous transform's tail (final read, done) has cleared.
    assign len_ok     = (log2_len_i != '0) && (int'(log2_len_i) <= ADDR_WIDTH);
    assign accept     = (state_q == S_IDLE) && start_i && !abort_i && !busy_q && !done_q;
    assign issue      = ((state_q == S_CALC) || (state_q == S_OUTP)) && !stall_i && !abort_i;
    assign len_mask   = ADDR_WIDTH'((32'd1 << len_q) - 32'd1);
    assign rc_last    = (rc_q == len_mask);
    assign level_last = (level_q == len_q - LOG2_LEN_W'(1));
    assign gap_last   = (gcnt_q == 4'(LEVEL_GAP - 1));

    assign b_idx     = rc_q >> 1;
    assign base      = ADDR_WIDTH'(insert_zero_bit(FN_W'(b_idx), level_q));
    assign pair      = base | (ADDR_WIDTH'(1) << level_q);
    assign bfly_addr = (rc_q[0] ? pair : base) & len_mask;
    assign out_addr  = bitrev_q ? ADDR_WIDTH'(bit_reverse(FN_W'(rc_q), 32'(len_q))) : rc_q;
    // Twiddle index scaled up to the full-length ROM so one table serves every N.
    assign tw_val    = TW_WIDTH'((32'(b_idx) & ((32'd1 << level_q) - 32'd1))
                                 << (TW_WIDTH - int'(level_q)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rc_q       <= '0;
            level_q    <= '0;
            len_q      <= '0;
            gcnt_q     <= '0;
            out_en_q   <= 1'b0;
            bitrev_q   <= 1'b0;
            pend_out_q <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            tw_addr_q  <= '0;
            lvl_out_q  <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            outp_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rc_q       <= rc_d;
            level_q    <= level_d;
            len_q      <= len_d;
            gcnt_q     <= gcnt_d;
            out_en_q   <= out_en_d;
            bitrev_q   <= bitrev_d;
            pend_out_q <= pend_out_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            tw_addr_q  <= tw_addr_d;
            lvl_out_q  <= lvl_out_d;
            first_q    <= first_d;
            last_q     <= last_d;
            outp_q     <= outp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            len_err_q  <= len_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rc_d       = rc_q;
        level_d    = level_q;
        len_d      = len_q;
        gcnt_d     = gcnt_q;
        out_en_d   = out_en_q;
        bitrev_d   = bitrev_q;
        pend_out_d = pend_out_q;
        if (abort_i) begin
            state_d    = S_IDLE;
            rc_d       = '0;
            level_d    = '0;
            gcnt_d     = '0;
            pend_out_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && len_ok) begin
                        state_d    = S_CALC;
                        rc_d       = '0;
                        level_d    = '0;
                        gcnt_d     = '0;
                        pend_out_d = 1'b0;
                        len_d      = log2_len_i;
                        out_en_d   = out_en_i;
                        bitrev_d   = bitrev_out_i;
                    end
                end
                S_CALC: begin
                    if (issue) begin
                        if (!rc_last) begin
                            rc_d = rc_q + ADDR_WIDTH'(1);
                        end else begin
                            rc_d = '0;
                            if (!level_last) begin
                                level_d = level_q + LOG2_LEN_W'(1);
                                state_d = (LEVEL_GAP > 0) ? S_GAP : S_CALC;
                            end else if (out_en_q) begin
                                pend_out_d = 1'b1;
                                state_d    = (LEVEL_GAP > 0) ? S_GAP : S_OUTP;
                            end else begin
                                level_d = '0;
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (!stall_i) begin
                        if (gap_last) begin
                            gcnt_d  = '0;
                            state_d = pend_out_q ? S_OUTP : S_CALC;
                        end else begin
                            gcnt_d = gcnt_q + 4'd1;
                        end
                    end
                end
                S_OUTP: begin
                    if (issue) begin
                        if (!rc_last) begin
                            rc_d = rc_q + ADDR_WIDTH'(1);
                        end else begin
                            rc_d       = '0;
                            level_d    = '0;
                            pend_out_d = 1'b0;
                            state_d    = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output registers describe the read being issued this cycle, one edge later.
    always_comb begin
        rd_en_d   = issue;
        rd_addr_d = rd_addr_q;
        tw_addr_d = tw_addr_q;
        if (abort_i) begin
            rd_addr_d = '0;
            tw_addr_d = '0;
        end else if (issue) begin
            rd_addr_d = (state_q == S_OUTP) ? (out_addr & len_mask) : bfly_addr;
            tw_addr_d = (state_q == S_OUTP) ? '0 : tw_val;
        end
        lvl_out_d = abort_i ? '0 : level_q;
        first_d   = !abort_i && (state_q == S_CALC) && (level_q == '0);
        last_d    = !abort_i && (state_q == S_CALC) && level_last;
        outp_d    = !abort_i && (state_q == S_OUTP);
        busy_d    = (state_d != S_IDLE) || issue;
        done_d    = (state_q == S_IDLE) && rd_en_q && !abort_i;
        len_err_d = accept && !len_ok;
    end

    fft_rd_valid_dly #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_valid_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (rd_en_q),
        .vld_o (rd_valid_o)
    );

    assign rd_en_o       = rd_en_q;
    assign rd_addr_o     = rd_addr_q;
    assign tw_addr_o     = tw_addr_q;
    assign level_o       = lvl_out_q;
    assign first_level_o = first_q;
    assign last_level_o  = last_q;
    assign out_phase_o   = outp_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign len_err_o     = len_err_q;

endmodule

// File: tb/tb_fft_rd_addr_gen.sv
// Directed bench for fft_rd_addr_gen at ADDR_WIDTH=4, LEVEL_GAP=2, RD_LATENCY=2.
module tb_fft_rd_addr_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] log2_len;
    logic       out_en;
    logic       bitrev_out;
    logic       stall;
    logic       abort;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [2:0] tw_addr;
    logic       rd_valid;
    logic [3:0] level;
    logic       first_level;
    logic       last_level;
    logic       out_phase;
    logic       busy;
    logic       done;
    logic       len_err;

    int checks   = 0;
    int failures = 0;

    logic       c_en   [64];
    logic [3:0] c_addr [64];
    logic [2:0] c_tw   [64];
    logic       c_vld  [64];
    logic       c_done [64];
    logic       c_busy [64];
    logic       c_oph  [64];
    logic       c_first[64];
    logic       c_last [64];
    logic [3:0] c_lvl  [64];
    logic       e_en   [64];

    int seq3  [24] = '{0,1,2,3,4,5,6,7, 0,2,1,3,4,6,5,7, 0,4,1,5,2,6,3,7};
    int tw3   [24] = '{0,0,0,0,0,0,0,0, 0,0,4,4,0,0,4,4, 0,0,2,2,4,4,6,6};
    int outp3 [8]  = '{0,4,2,6,1,5,3,7};
    int seq2  [8]  = '{0,1,2,3, 0,2,1,3};
    int tw2   [8]  = '{0,0,0,0, 0,0,4,4};

    fft_rd_addr_gen #(
        .ADDR_WIDTH (4),
        .TW_WIDTH   (3),
        .LEVEL_GAP  (2),
        .RD_LATENCY (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .log2_len_i    (log2_len),
        .out_en_i      (out_en),
        .bitrev_out_i  (bitrev_out),
        .stall_i       (stall),
        .abort_i       (abort),
        .rd_en_o       (rd_en),
        .rd_addr_o     (rd_addr),
        .tw_addr_o     (tw_addr),
        .rd_valid_o    (rd_valid),
        .level_o       (level),
        .first_level_o (first_level),
        .last_level_o  (last_level),
        .out_phase_o   (out_phase),
        .busy_o        (busy),
        .done_o        (done),
        .len_err_o     (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] len, input logic oen, input logic brev);
        log2_len   = len;
        out_en     = oen;
        bitrev_out = brev;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // Records ncyc cycles; t=0 is the cycle after the edge following the start edge.
    task automatic capture(input int ncyc, input int stall_at, input int stall_len,
                           input int abort_at, input int restart_at, input logic [3:0] restart_len);
        for (int t = 0; t < ncyc; t++) begin
            step();
            c_en[t]    = rd_en;
            c_addr[t]  = rd_addr;
            c_tw[t]    = tw_addr;
            c_vld[t]   = rd_valid;
            c_done[t]  = done;
            c_busy[t]  = busy;
            c_oph[t]   = out_phase;
            c_first[t] = first_level;
            c_last[t]  = last_level;
            c_lvl[t]   = level;
            stall = (t >= stall_at) && (t < stall_at + stall_len);
            abort = (t == abort_at);
            start = (t == restart_at);
            if (t == restart_at) log2_len = restart_len;
        end
        stall = 1'b0;
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; log2_len = '0; out_en = 1'b0; bitrev_out = 1'b0;
        stall = 1'b0; abort = 1'b0;
        repeat (3) step();
        checks++;
        if ({rd_en, rd_valid, first_level, last_level, out_phase, busy, done, len_err} !== 8'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000000",
                     {rd_en, rd_valid, first_level, last_level, out_phase, busy, done, len_err});
        end
        checks++;
        if ({rd_addr, tw_addr, level} !== 11'b0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", rd_addr, tw_addr, level);
        end
        rst_n = 1'b1;
        repeat (2) step();
        checks++;
        if ({rd_en, rd_valid, busy, done, len_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=00000", {rd_en, rd_valid, busy, done, len_err});
        end
    endtask

    task automatic test_levels();
        int k;
        do_start(4'd3, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1 || rd_en !== 1'b0) begin
            failures++;
            $display("FAIL levels_start busy=%b rd_en=%b exp busy=1 rd_en=0", busy, rd_en);
        end
        capture(31, -1, 0, -1, 28, 4'd3);
        k = 0;
        for (int t = 0; t < 31; t++) begin
            e_en[t] = (t < 8) || (t >= 10 && t < 18) || (t >= 20 && t < 28);
            checks++;
            if (c_en[t] !== e_en[t]) begin
                failures++; $display("FAIL levels_rd_en t=%0d got=%b exp=%b", t, c_en[t], e_en[t]);
            end
            if (e_en[t]) begin
                checks++;
                if (c_addr[t] !== 4'(seq3[k])) begin
                    failures++; $display("FAIL levels_addr t=%0d got=%0d exp=%0d", t, c_addr[t], seq3[k]);
                end
                checks++;
                if (c_tw[t] !== 3'(tw3[k])) begin
                    failures++; $display("FAIL levels_tw t=%0d got=%0d exp=%0d", t, c_tw[t], tw3[k]);
                end
                checks++;
                if (c_lvl[t] !== 4'(k / 8)) begin
                    failures++; $display("FAIL levels_level t=%0d got=%0d exp=%0d", t, c_lvl[t], k / 8);
                end
                k++;
            end
            checks++;
            if (c_first[t] !== (t < 8)) begin
                failures++; $display("FAIL levels_first t=%0d got=%b exp=%b", t, c_first[t], (t < 8));
            end
            checks++;
            if (c_last[t] !== (t >= 20 && t < 28)) begin
                failures++; $display("FAIL levels_last t=%0d got=%b exp=%b", t, c_last[t], (t >= 20 && t < 28));
            end
            checks++;
            if (c_vld[t] !== ((t >= 2) ? e_en[t-2] : 1'b0)) begin
                failures++; $display("FAIL levels_rd_valid t=%0d got=%b", t, c_vld[t]);
            end
            checks++;
            if (c_done[t] !== (t == 28)) begin
                failures++; $display("FAIL levels_done t=%0d got=%b exp=%b", t, c_done[t], (t == 28));
            end
            checks++;
            if (c_busy[t] !== (t < 28)) begin
                failures++; $display("FAIL levels_busy t=%0d got=%b exp=%b", t, c_busy[t], (t < 28));
            end
        end
    endtask

    task automatic test_outpass();
        int k;
        do_start(4'd3, 1'b1, 1'b1);
        capture(40, -1, 0, -1, -1, 4'd0);
        k = 0;
        for (int t = 0; t < 40; t++) begin
            e_en[t] = (t < 8) || (t >= 10 && t < 18) || (t >= 20 && t < 28) || (t >= 30 && t < 38);
            checks++;
            if (c_en[t] !== e_en[t]) begin
                failures++; $display("FAIL outp_rd_en t=%0d got=%b exp=%b", t, c_en[t], e_en[t]);
            end
            if (e_en[t]) begin
                checks++;
                if (c_addr[t] !== 4'((k < 24) ? seq3[k] : outp3[k-24])) begin
                    failures++; $display("FAIL outp_addr t=%0d got=%0d k=%0d", t, c_addr[t], k);
                end
                checks++;
                if (c_tw[t] !== 3'((k < 24) ? tw3[k] : 0)) begin
                    failures++; $display("FAIL outp_tw t=%0d got=%0d k=%0d", t, c_tw[t], k);
                end
                k++;
            end
            checks++;
            if (c_oph[t] !== (t >= 30 && t < 38)) begin
                failures++; $display("FAIL outp_phase t=%0d got=%b exp=%b", t, c_oph[t], (t >= 30 && t < 38));
            end
            checks++;
            if (c_done[t] !== (t == 38)) begin
                failures++; $display("FAIL outp_done t=%0d got=%b exp=%b", t, c_done[t], (t == 38));
            end
        end
    endtask

    task automatic test_stall();
        int k;
        do_start(4'd3, 1'b0, 1'b0);
        capture(33, 11, 3, -1, -1, 4'd0);
        k = 0;
        for (int t = 0; t < 33; t++) begin
            e_en[t] = (t < 8) || (t >= 10 && t < 12) || (t >= 15 && t < 21) || (t >= 23 && t < 31);
            checks++;
            if (c_en[t] !== e_en[t]) begin
                failures++; $display("FAIL stall_rd_en t=%0d got=%b exp=%b", t, c_en[t], e_en[t]);
            end
            if (e_en[t]) begin
                checks++;
                if (c_addr[t] !== 4'(seq3[k]) || c_tw[t] !== 3'(tw3[k])) begin
                    failures++;
                    $display("FAIL stall_addr t=%0d got=%0d/%0d exp=%0d/%0d", t, c_addr[t], c_tw[t], seq3[k], tw3[k]);
                end
                k++;
            end else if (t >= 12 && t < 15) begin
                checks++;
                if (c_addr[t] !== 4'd2 || c_tw[t] !== 3'd0) begin
                    failures++; $display("FAIL stall_hold t=%0d got=%0d/%0d exp=2/0", t, c_addr[t], c_tw[t]);
                end
            end
            checks++;
            if (c_vld[t] !== ((t >= 2) ? e_en[t-2] : 1'b0)) begin
                failures++; $display("FAIL stall_rd_valid t=%0d got=%b", t, c_vld[t]);
            end
            checks++;
            if (c_done[t] !== (t == 31) || c_busy[t] !== (t < 31)) begin
                failures++; $display("FAIL stall_done_busy t=%0d got=%b%b", t, c_done[t], c_busy[t]);
            end
        end
    endtask

    task automatic test_len_err();
        logic [3:0] bad [2];
        bad[0] = 4'd0;
        bad[1] = 4'd5;
        for (int i = 0; i < 2; i++) begin
            do_start(bad[i], 1'b0, 1'b0);
            checks++;
            if (len_err !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
                failures++;
                $display("FAIL len_err_pulse len=%0d got err=%b busy=%b rd_en=%b exp 1/0/0", bad[i], len_err, busy, rd_en);
            end
            for (int t = 0; t < 4; t++) begin
                step();
                checks++;
                if (len_err !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
                    failures++;
                    $display("FAIL len_err_after len=%0d t=%0d got err=%b busy=%b rd_en=%b", bad[i], t, len_err, busy, rd_en);
                end
            end
        end
        do_start(4'd4, 1'b0, 1'b0);
        checks++;
        if (len_err !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL len_max_legal got err=%b busy=%b exp 0/1", len_err, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            failures++; $display("FAIL len_max_abort got busy=%b rd_en=%b exp 0/0", busy, rd_en);
        end
        repeat (3) step();
    endtask

    task automatic test_abort();
        int k;
        do_start(4'd3, 1'b0, 1'b0);
        capture(20, -1, 0, 12, -1, 4'd0);
        for (int t = 0; t < 20; t++) begin
            e_en[t] = (t < 8) || (t >= 10 && t < 13);
            checks++;
            if (c_en[t] !== e_en[t]) begin
                failures++; $display("FAIL abort_rd_en t=%0d got=%b exp=%b", t, c_en[t], e_en[t]);
            end
            checks++;
            if (c_busy[t] !== (t < 13) || c_done[t] !== 1'b0) begin
                failures++; $display("FAIL abort_busy_done t=%0d got=%b%b", t, c_busy[t], c_done[t]);
            end
        end
        checks++;
        if (c_vld[13] !== 1'b1 || c_vld[14] !== 1'b1 || c_vld[15] !== 1'b0) begin
            failures++;
            $display("FAIL abort_drain got=%b%b%b exp=110", c_vld[13], c_vld[14], c_vld[15]);
        end
        do_start(4'd2, 1'b0, 1'b0);
        capture(12, -1, 0, -1, -1, 4'd0);
        k = 0;
        for (int t = 0; t < 12; t++) begin
            e_en[t] = (t < 4) || (t >= 6 && t < 10);
            checks++;
            if (c_en[t] !== e_en[t]) begin
                failures++; $display("FAIL restart_rd_en t=%0d got=%b exp=%b", t, c_en[t], e_en[t]);
            end
            if (e_en[t]) begin
                checks++;
                if (c_addr[t] !== 4'(seq2[k]) || c_tw[t] !== 3'(tw2[k])) begin
                    failures++;
                    $display("FAIL restart_addr t=%0d got=%0d/%0d exp=%0d/%0d", t, c_addr[t], c_tw[t], seq2[k], tw2[k]);
                end
                k++;
            end
            checks++;
            if (c_done[t] !== (t == 10)) begin
                failures++; $display("FAIL restart_done t=%0d got=%b exp=%b", t, c_done[t], (t == 10));
            end
        end
    endtask

    task automatic test_busy_start_reset();
        int k;
        do_start(4'd3, 1'b0, 1'b0);
        capture(16, -1, 0, -1, 3, 4'd2);
        k = 0;
        for (int t = 0; t < 16; t++) begin
            e_en[t] = (t < 8) || (t >= 10);
            checks++;
            if (c_en[t] !== e_en[t]) begin
                failures++; $display("FAIL busy_start_rd_en t=%0d got=%b exp=%b", t, c_en[t], e_en[t]);
            end
            if (e_en[t]) begin
                checks++;
                if (c_addr[t] !== 4'(seq3[k])) begin
                    failures++; $display("FAIL busy_start_addr t=%0d got=%0d exp=%0d", t, c_addr[t], seq3[k]);
                end
                k++;
            end
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, rd_valid, first_level, last_level, out_phase, busy, done, len_err} !== 8'b0) begin
            failures++;
            $display("FAIL async_reset_ctrl got=%b exp=00000000",
                     {rd_en, rd_valid, first_level, last_level, out_phase, busy, done, len_err});
        end
        checks++;
        if ({rd_addr, tw_addr, level} !== 11'b0) begin
            failures++; $display("FAIL async_reset_data got=%h/%h/%h exp=0/0/0", rd_addr, tw_addr, level);
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            checks++;
            if ({rd_en, rd_valid, busy, done} !== 4'b0) begin
                failures++; $display("FAIL post_reset t=%0d got=%b exp=0000", t, {rd_en, rd_valid, busy, done});
            end
        end
    endtask

    initial begin
        test_reset();
        test_levels();
        test_outpass();
        test_stall();
        test_len_err();
        test_abort();
        test_busy_start_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
